execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  ID/EX pipeline register plus EX-stage datapath of the 5-stage RV32I core. Captures decode outputs
//  each clk, applies forwarding to both operands, runs the ALU, resolves branches/jumps and drives
//  PCSrcE/PCTargetE back to fetch. Registered E-stage outputs feed the EX/MEM register in memory stage.
// PARAMETERS
//  WIDTH    32  datapath / address width
// PORTS
//  clk          in   1      core clock; all state updates on rising edge
//  rst          in   1      synchronous, active-high reset
//  FlushE       in   1      hazard unit: load a bubble into ID/EX next edge
//  ForwardAE    in   2      operand A select: 00 RD1E, 01 ResultW, 10 ALUResultM
//  ForwardBE    in   2      operand B select (pre-ALUSrc mux), same encoding
//  ResultW      in   WIDTH  writeback-stage result (forward source)
//  ALUResultM   in   WIDTH  memory-stage ALU result (forward source)
//  RegWriteD / MemWriteD / JumpD / BranchD / ALUSrcD / JALRctrlD   in 1 each   decode control
//  ResultSrcD   in   2      00 ALU, 01 mem, 10 PC+4
//  ALUControlD  in   3      ALU op (see BEHAVIOUR)
//  Funct3D      in   3      branch condition selector
//  RD1D, RD2D, PCD, ImmExtD, PCPlus4D   in WIDTH   decode data
//  Rs1D, Rs2D, RdD   in   5 each   register indices
//  RegWriteE, MemWriteE   out 1    registered control to memory stage
//  ResultSrcE   out  2      registered; bit0 used by hazard unit for load-use detect
//  PCSrcE       out  1      redirect fetch (taken branch or jump)
//  ALUResultE, WriteDataE, PCTargetE, PCPlus4E   out WIDTH
//  Rs1E, Rs2E, RdE   out  5 each   to hazard unit / memory stage
// BEHAVIOUR
//  - ID/EX register: on edge, if rst or FlushE -> every field (control and data) := 0; else load *D.
//    rst and FlushE simultaneous -> same zero result. Zeroed entry = add x0,x0,x0 with no side effects.
//  - Reset: all outputs 0 (with ForwardAE/BE = 00); PCSrcE = 0, PCTargetE = 0.
//  - Latency: D inputs visible on E outputs one cycle later; EX logic combinational from register.
//  - SrcAE = mux(ForwardAE); WriteDataE = mux(ForwardBE); SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
//    ForwardAE/BE = 11 is illegal; treat as 00.
//  - ALUControl: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed), 110 sll, 111 srl;
//    shifts use SrcBE[4:0]. All arithmetic modulo 2^WIDTH, no overflow flag. ZeroE = (ALUResultE == 0).
//  - Branch cond (Funct3E): 000 beq ZeroE; 001 bne !ZeroE; 100 blt / 101 bge from slt bit0; others not taken.
//    Decode sets ALUControl sub for beq/bne, slt for blt/bge.
//  - PCSrcE = JumpE | (BranchE & cond). Asserted only on registered (non-flushed) entries.
//  - PCTargetE = JALRctrlE ? ((SrcAE + ImmExtE) & ~1) : (PCE + ImmExtE); JALR uses forwarded SrcAE.
//  - Same cycle PCSrcE=1 and FlushE=1 (hazard unit flushes on redirect): current E-stage outputs valid
//    this cycle, bubble loaded next edge.
//  - Rs1E/Rs2E/RdE pass through register unchanged; RdE = 0 never causes forwarding (hazard unit rule).
// STRUCTURE
//  - cpu_pkg: WIDTH default, ALU op localparams, FWD_REG/FWD_WB/FWD_MEM, RESULT_* and BR_* encodings.
//  - One sub-module: alu (SrcA, SrcB, ALUControl -> Result, Zero), purely combinational.
//  - ID/EX register in one always_ff; forwarding, branch and target logic in always_comb here.
// TESTING
//  - Reset: rst=1 two cycles with nonzero D inputs -> all E outputs 0, PCSrcE=0.
//  - ALU: RD1D=5, RD2D=7, ALUControlD=001, fwd 00 -> next cycle ALUResultE=0xFFFFFFFE; slt gives 1.
//  - Forwarding: RD1D=1, ALUResultM=0x100, ForwardAE=10, ImmExtD=4, ALUSrcD=1, add -> ALUResultE=0x104;
//    ForwardAE=01 with ResultW=0x20 -> 0x24.
//  - Branch: BranchD=1, Funct3D=001, sub on 3,3 -> PCSrcE=0; on 3,4 -> PCSrcE=1, PCTargetE=PCD+ImmExtD
//    (PCD=0x40, Imm=0x10 -> 0x50).
//  - JALR: JumpD=1, JALRctrlD=1, SrcAE=0x1001, Imm=0x4 -> PCTargetE=0x1004, PCSrcE=1, PCPlus4E passed.
//  - Flush: valid jump in D with FlushE=1 -> next cycle PCSrcE=0, RegWriteE=0, RdE=0; rst+FlushE same.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared encodings for the execute stage of the RV32I core.
//  - DATA_WIDTH : default datapath / address width
//  - alu_op_e   : ALUControl encodings
//  - fwd_sel_e  : ForwardAE/ForwardBE encodings (2'b11 is illegal, treated as FWD_REG)
//  - result_src_e : ResultSrc encodings
//  - br_cond_e  : Funct3 branch condition encodings
//  - ex_ctrl_t  : control half of the ID/EX pipeline register
package execute_stage_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RESULT_ALU = 2'b00,
    RESULT_MEM = 2'b01,
    RESULT_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    BR_BEQ = 3'b000,
    BR_BNE = 3'b001,
    BR_BLT = 3'b100,
    BR_BGE = 3'b101
  } br_cond_e;

  // All-zero value of this struct is a harmless bubble (add x0,x0,x0, no writes).
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic       jalr;
    logic [1:0] result_src;
    logic [2:0] alu_control;
    logic [2:0] funct3;
  } ex_ctrl_t;

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU for the execute stage.
//  i_src_a, i_src_b : operands
//  i_alu_control    : operation (alu_op_e encoding)
//  o_result         : result, modulo 2^WIDTH
//  o_zero           : o_result == 0
module execute_stage_alu
  import execute_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  input  logic [2:0]       i_alu_control,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero
);

  logic [4:0] w_shamt;
  logic       w_lt;

  assign w_shamt = i_src_b[4:0];
  assign w_lt    = $signed(i_src_a) < $signed(i_src_b);

  always_comb begin
    o_result = '0;
    case (i_alu_control)
      ALU_ADD: o_result = i_src_a + i_src_b;
      ALU_SUB: o_result = i_src_a - i_src_b;
      ALU_AND: o_result = i_src_a & i_src_b;
      ALU_OR:  o_result = i_src_a | i_src_b;
      ALU_XOR: o_result = i_src_a ^ i_src_b;
      ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, w_lt};
      ALU_SLL: o_result = i_src_a << w_shamt;
      ALU_SRL: o_result = i_src_a >> w_shamt;
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/execute_stage.sv
// ID/EX pipeline register plus EX-stage datapath of the 5-stage RV32I core.
//  Inputs : clk, rst (sync, active-high), FlushE, ForwardAE/BE, ResultW, ALUResultM,
//           decode control (*D) and decode data/register indices (*D).
//  Outputs: registered control (RegWriteE, MemWriteE, ResultSrcE), redirect (PCSrcE, PCTargetE),
//           ALUResultE, WriteDataE, PCPlus4E and register indices Rs1E/Rs2E/RdE.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             FlushE,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic             JALRctrlD,
  input  logic [1:0]       ResultSrcD,
  input  logic [2:0]       ALUControlD,
  input  logic [2:0]       Funct3D,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] PCD,
  input  logic [WIDTH-1:0] ImmExtD,
  input  logic [WIDTH-1:0] PCPlus4D,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic [1:0]       ResultSrcE,
  output logic             PCSrcE,
  output logic [WIDTH-1:0] ALUResultE,
  output logic [WIDTH-1:0] WriteDataE,
  output logic [WIDTH-1:0] PCTargetE,
  output logic [WIDTH-1:0] PCPlus4E,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE
);

  ex_ctrl_t         r_ctrl;
  logic [WIDTH-1:0] r_rd1, r_rd2, r_pc, r_imm, r_pcp4;
  logic [4:0]       r_rs1, r_rs2, r_rd;

  logic [WIDTH-1:0] w_src_a, w_write_data, w_src_b, w_alu_result, w_jalr_sum;
  logic             w_zero, w_cond;

  // Reset and flush both load an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      r_ctrl <= '0;
      r_rd1  <= '0;
      r_rd2  <= '0;
      r_pc   <= '0;
      r_imm  <= '0;
      r_pcp4 <= '0;
      r_rs1  <= '0;
      r_rs2  <= '0;
      r_rd   <= '0;
    end else begin
      r_ctrl <= '{reg_write:   RegWriteD,
                  mem_write:   MemWriteD,
                  jump:        JumpD,
                  branch:      BranchD,
                  alu_src:     ALUSrcD,
                  jalr:        JALRctrlD,
                  result_src:  ResultSrcD,
                  alu_control: ALUControlD,
                  funct3:      Funct3D};
      r_rd1  <= RD1D;
      r_rd2  <= RD2D;
      r_pc   <= PCD;
      r_imm  <= ImmExtD;
      r_pcp4 <= PCPlus4D;
      r_rs1  <= Rs1D;
      r_rs2  <= Rs2D;
      r_rd   <= RdD;
    end
  end

  // Operand forwarding; the illegal 2'b11 select falls back to the register value.
  always_comb begin
    w_src_a = r_rd1;
    case (ForwardAE)
      FWD_WB:  w_src_a = ResultW;
      FWD_MEM: w_src_a = ALUResultM;
      default: w_src_a = r_rd1;
    endcase

    w_write_data = r_rd2;
    case (ForwardBE)
      FWD_WB:  w_write_data = ResultW;
      FWD_MEM: w_write_data = ALUResultM;
      default: w_write_data = r_rd2;
    endcase

    w_src_b = r_ctrl.alu_src ? r_imm : w_write_data;
  end

  execute_stage_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .i_src_a      (w_src_a),
    .i_src_b      (w_src_b),
    .i_alu_control(r_ctrl.alu_control),
    .o_result     (w_alu_result),
    .o_zero       (w_zero)
  );

  // Decode pairs beq/bne with sub and blt/bge with slt, so bit 0 of the result is the
  // signed less-than flag for the latter.
  always_comb begin
    w_cond = 1'b0;
    case (r_ctrl.funct3)
      BR_BEQ:  w_cond = w_zero;
      BR_BNE:  w_cond = ~w_zero;
      BR_BLT:  w_cond = w_alu_result[0];
      BR_BGE:  w_cond = ~w_alu_result[0];
      default: w_cond = 1'b0;
    endcase
  end

  assign w_jalr_sum = w_src_a + r_imm;

  always_comb begin
    PCSrcE    = r_ctrl.jump | (r_ctrl.branch & w_cond);
    PCTargetE = r_ctrl.jalr ? {w_jalr_sum[WIDTH-1:1], 1'b0} : (r_pc + r_imm);
  end

  assign RegWriteE  = r_ctrl.reg_write;
  assign MemWriteE  = r_ctrl.mem_write;
  assign ResultSrcE = r_ctrl.result_src;
  assign ALUResultE = w_alu_result;
  assign WriteDataE = w_write_data;
  assign PCPlus4E   = r_pcp4;
  assign Rs1E       = r_rs1;
  assign Rs2E       = r_rs2;
  assign RdE        = r_rd;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        FlushE = 1'b0;
  logic [1:0]  ForwardAE = '0, ForwardBE = '0;
  logic [31:0] ResultW = '0, ALUResultM = '0;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRctrlD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD, Funct3D;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        RegWriteE, MemWriteE, PCSrcE;
  logic [1:0]  ResultSrcE;
  logic [31:0] ALUResultE, WriteDataE, PCTargetE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;

  typedef struct packed {
    logic        rw, mw, jump, branch, alu_src, jalr;
    logic [1:0]  res_src;
    logic [2:0]  op, f3;
    logic [31:0] rd1, rd2, pc, imm, pcp4;
    logic [4:0]  rs1, rs2, rd;
  } dec_t;

  typedef struct packed {
    logic        rw, mw;
    logic [1:0]  res_src;
    logic        pcsrc;
    logic [31:0] alu, wd, tgt, pcp4;
    logic [4:0]  rs1, rs2, rd;
  } out_t;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst(rst), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .ALUResultM(ALUResultM), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
    .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD), .JALRctrlD(JALRctrlD),
    .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD), .Funct3D(Funct3D), .RD1D(RD1D),
    .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RdD(RdD), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCTargetE(PCTargetE),
    .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
    end
  endtask

  // Reference: instruction-level meaning of one E-stage entry under the current forward inputs.
  function automatic out_t model(input dec_t e, input logic [1:0] fa, input logic [1:0] fb,
                                 input logic [31:0] resw, input logic [31:0] alum);
    out_t        o;
    logic [31:0] a, wd, b, r;
    logic        taken;
    a  = (fa == 2'd1) ? resw : (fa == 2'd2) ? alum : e.rd1;
    wd = (fb == 2'd1) ? resw : (fb == 2'd2) ? alum : e.rd2;
    b  = e.alu_src ? e.imm : wd;
    case (e.op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: r = a << b[4:0];
      default: r = a >> b[4:0];
    endcase
    // Branch entries carry the decode-matched op, so compare operands directly.
    case (e.f3)
      3'd0: taken = (a == b);
      3'd1: taken = (a != b);
      3'd4: taken = ($signed(a) < $signed(b));
      3'd5: taken = !($signed(a) < $signed(b));
      default: taken = 1'b0;
    endcase
    o.rw      = e.rw;
    o.mw      = e.mw;
    o.res_src = e.res_src;
    o.pcsrc   = e.jump | (e.branch & taken);
    o.alu     = r;
    o.wd      = wd;
    o.tgt     = e.jalr ? ((a + e.imm) & 32'hFFFF_FFFE) : (e.pc + e.imm);
    o.pcp4    = e.pcp4;
    o.rs1     = e.rs1;
    o.rs2     = e.rs2;
    o.rd      = e.rd;
    return o;
  endfunction

  task automatic check_out(input string tag, input out_t w);
    check({tag, ".regwrite"},  {31'd0, RegWriteE}, {31'd0, w.rw});
    check({tag, ".memwrite"},  {31'd0, MemWriteE}, {31'd0, w.mw});
    check({tag, ".resultsrc"}, {30'd0, ResultSrcE}, {30'd0, w.res_src});
    check({tag, ".pcsrc"},     {31'd0, PCSrcE}, {31'd0, w.pcsrc});
    check({tag, ".aluresult"}, ALUResultE, w.alu);
    check({tag, ".writedata"}, WriteDataE, w.wd);
    check({tag, ".pctarget"},  PCTargetE, w.tgt);
    check({tag, ".pcplus4"},   PCPlus4E, w.pcp4);
    check({tag, ".rs1"},       {27'd0, Rs1E}, {27'd0, w.rs1});
    check({tag, ".rs2"},       {27'd0, Rs2E}, {27'd0, w.rs2});
    check({tag, ".rd"},        {27'd0, RdE}, {27'd0, w.rd});
  endtask

  // Drive one decode entry, clock it in, and land 1 time unit after the edge.
  task automatic step(input dec_t d, input logic fl, input logic r);
    RegWriteD = d.rw;     MemWriteD = d.mw;      JumpD = d.jump;      BranchD = d.branch;
    ALUSrcD = d.alu_src;  JALRctrlD = d.jalr;    ResultSrcD = d.res_src;
    ALUControlD = d.op;   Funct3D = d.f3;        RD1D = d.rd1;        RD2D = d.rd2;
    PCD = d.pc;           ImmExtD = d.imm;       PCPlus4D = d.pcp4;
    Rs1D = d.rs1;         Rs2D = d.rs2;          RdD = d.rd;
    FlushE = fl;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  function automatic dec_t rand_dec();
    dec_t d;
    d = dec_t'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    d.f3 = 3'd2;
    if (d.branch) begin
      case ($urandom_range(4))
        0: begin d.f3 = 3'd0; d.op = 3'd1; end
        1: begin d.f3 = 3'd1; d.op = 3'd1; end
        2: begin d.f3 = 3'd4; d.op = 3'd5; end
        3: begin d.f3 = 3'd5; d.op = 3'd5; end
        default: d.f3 = 3'd2;
      endcase
      d.alu_src = 1'b0;
    end
    d.jump = ($urandom_range(5) == 0);
    if ($urandom_range(3) == 0) d.rd2 = d.rd1;
    return d;
  endfunction

  initial begin
    dec_t d, held;
    out_t w;
    logic fl, r;

    // Reset with garbage on the D side.
    d = rand_dec();
    d.jump = 1'b1;
    d.rw   = 1'b1;
    step(d, 1'b0, 1'b1);
    step(d, 1'b0, 1'b1);
    check_out("reset", '0);

    // sub 5-7 wraps, slt 5<7.
    d = '0; d.rd1 = 32'd5; d.rd2 = 32'd7; d.op = 3'd1;
    step(d, 1'b0, 1'b0);
    check("sub_wrap", ALUResultE, 32'hFFFF_FFFE);
    d.op = 3'd5;
    step(d, 1'b0, 1'b0);
    check("slt", ALUResultE, 32'd1);

    // Forwarding into operand A with immediate operand B.
    d = '0; d.rd1 = 32'd1; d.imm = 32'd4; d.alu_src = 1'b1;
    ALUResultM = 32'h100; ForwardAE = 2'b10;
    step(d, 1'b0, 1'b0);
    check("fwd_mem", ALUResultE, 32'h104);
    ResultW = 32'h20; ForwardAE = 2'b01;
    #1;
    check("fwd_wb", ALUResultE, 32'h24);
    ForwardAE = 2'b11;
    #1;
    check("fwd_illegal", ALUResultE, 32'h5);
    ForwardAE = 2'b00;

    // bne: equal -> not taken, unequal -> taken to PC+imm.
    d = '0; d.branch = 1'b1; d.f3 = 3'd1; d.op = 3'd1;
    d.rd1 = 32'd3; d.rd2 = 32'd3; d.pc = 32'h40; d.imm = 32'h10;
    step(d, 1'b0, 1'b0);
    check("bne_eq.pcsrc", {31'd0, PCSrcE}, 32'd0);
    d.rd2 = 32'd4;
    step(d, 1'b0, 1'b0);
    check("bne_ne.pcsrc", {31'd0, PCSrcE}, 32'd1);
    check("bne_ne.target", PCTargetE, 32'h50);

    // JALR clears bit 0 of the target.
    d = '0; d.jump = 1'b1; d.jalr = 1'b1; d.rd1 = 32'h1001; d.imm = 32'h4;
    d.pcp4 = 32'h1234; d.rd = 5'd5; d.rw = 1'b1; d.res_src = 2'b10;
    step(d, 1'b0, 1'b0);
    check("jalr.target", PCTargetE, 32'h1004);
    check("jalr.pcsrc", {31'd0, PCSrcE}, 32'd1);
    check("jalr.pcplus4", PCPlus4E, 32'h1234);

    // Flush (alone and together with reset) turns the jump into a bubble.
    step(d, 1'b1, 1'b0);
    check_out("flush", '0);
    step(d, 1'b1, 1'b1);
    check_out("flush_rst", '0);
    step(d, 1'b0, 1'b0);
    check("after_flush.pcsrc", {31'd0, PCSrcE}, 32'd1);

    // Random entries, flushes, resets and forward selects.
    for (int i = 0; i < 300; i++) begin
      d  = rand_dec();
      fl = ($urandom_range(5) == 0);
      r  = ($urandom_range(30) == 0);
      held = (fl || r) ? dec_t'('0) : d;
      ForwardAE  = 2'($urandom_range(3));
      ForwardBE  = 2'($urandom_range(3));
      ResultW    = $urandom();
      ALUResultM = $urandom();
      step(d, fl, r);
      w = model(held, ForwardAE, ForwardBE, ResultW, ALUResultM);
      check_out("rand", w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
